full_spi: RTL and testbench

Single-clock SPI master byte engine for the SD-card audio/video peripheral. It generates SPI_CLK from MasterCLK with two runtime-selectable rates: slow for card initialization, fast for data transfer. It shifts bytes full-duplex, MSB first, in SPI mode 0, back to back while enabled. It signals each byte boundary to the SD command state machine with a one-cycle DataClk strobe.

---
 rtl/full_spi_if.sv | 48 ++++
 rtl/full_spi.sv | 174 +++++++++++++++++
 tb/tb_full_spi.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/full_spi_if.sv
// full_spi_if: signal bundle between the SD-card SPI byte engine and its user.
//
// The master modport is the byte engine (full_spi). The slave modport is the
// side that supplies bytes and drives MISO, i.e. the SD command state machine
// together with the card.
//
// Handshake: there is no valid/ready pair. While SPI_Enable=1 the engine runs
// continuously. DataClk is a one-cycle strobe marking a byte boundary:
//   - in that cycle InputData holds the byte just received;
//   - OutputData and SPI_FastMode were already sampled on the edge that raised
//     DataClk.
// A new OutputData written in response to the strobe is therefore sent one
// byte later. dbg_shift mirrors the engine state (1 = SHIFT) for observation.
interface full_spi_if;
    logic       SPI_Enable;
    logic       SPI_FastMode;
    logic [7:0] OutputData;
    logic [7:0] InputData;
    logic       DataClk;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic       SPI_CLK;
    logic       dbg_shift;

    modport master (
        input  SPI_Enable,
        input  SPI_FastMode,
        input  OutputData,
        input  SPI_MISO,
        output InputData,
        output DataClk,
        output SPI_MOSI,
        output SPI_CLK,
        output dbg_shift
    );

    modport slave (
        output SPI_Enable,
        output SPI_FastMode,
        output OutputData,
        output SPI_MISO,
        input  InputData,
        input  DataClk,
        input  SPI_MOSI,
        input  SPI_CLK,
        input  dbg_shift
    );
endinterface

// File: rtl/full_spi.sv
// full_spi: single-clock SPI mode-0 master byte engine for the SD-card port.
//
// SPI_CLK is divided from MasterCLK. The rate (slow for card init, fast for
// data) is chosen at each byte load. Bytes are shifted full duplex, MSB first,
// back to back while SPI_Enable=1, and DataClk pulses at each byte boundary.
//
// Build option: define FULL_SPI_LOOPBACK_EN to receive from the internal MOSI
// value instead of SPI_MISO, for self-test. Undefined is the production build.
module full_spi #(
    parameter int MasterFrequency = 50000000,
    parameter int SlowFrequency   = 350000,
    parameter int FastFrequency   = 12500000
) (
    input  logic       MasterCLK,
    input  logic       Reset,
    full_spi_if.master bus
);

    // Half-period in MasterCLK cycles for each rate, never below one cycle.
    localparam int HSlowRaw = MasterFrequency / (2 * SlowFrequency);
    localparam int HFastRaw = MasterFrequency / (2 * FastFrequency);
    localparam int HSlow    = (HSlowRaw < 1) ? 1 : HSlowRaw;
    localparam int HFast    = (HFastRaw < 1) ? 1 : HFastRaw;
    localparam int HMax     = (HSlow > HFast) ? HSlow : HFast;

    // The divider counts 0 .. H-1, so it only needs to hold HMax-1.
    localparam int DivW = (HMax > 1) ? $clog2(HMax) : 1;
    localparam logic [DivW-1:0] HSlowLast = DivW'(HSlow - 1);
    localparam logic [DivW-1:0] HFastLast = DivW'(HFast - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      din_q, din_d;
    logic            fast_q, fast_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            dclk_q, dclk_d;

    logic [DivW-1:0] half_last;
    logic            half_done;
    logic            load;
    logic            park;
    logic            rx_bit;

`ifdef FULL_SPI_LOOPBACK_EN
    // Self-test: the bit on the wire is looped straight back into RX.
    logic unused_miso;
    assign unused_miso = bus.SPI_MISO;
    assign rx_bit      = mosi_q;
`else
    // Production: MISO is sampled directly. The card drives it in step with
    // our own SPI_CLK, so no synchronizer is used.
    assign rx_bit = bus.SPI_MISO;
`endif

    // Decode the divider terminal count for the rate latched at the last load,
    // plus the load / park conditions.
    always_comb begin
        half_last = fast_q ? HFastLast : HSlowLast;
        half_done = (state_q == ST_SHIFT) && (div_q == half_last);
        load      = (state_q == ST_IDLE) && bus.SPI_Enable;
        park      = (state_q == ST_IDLE) || !bus.SPI_Enable;
    end

    // FSM next state: enable starts a transfer; dropping enable aborts it at
    // once from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.SPI_Enable)  state_d = ST_SHIFT;
            ST_SHIFT: if (!bus.SPI_Enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next state.
    // Each SPI_CLK edge is a divider wrap:
    //   - rising edge: sample the RX bit;
    //   - falling edge: shift TX, or finish the byte and reload.
    always_comb begin
        div_d  = div_q;
        bit_d  = bit_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        din_d  = din_q;
        fast_d = fast_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        dclk_d = 1'b0;

        if (park) begin
            // Idle or abort: clock low, MOSI high, and any partial byte is
            // dropped. InputData is left untouched.
            div_d  = '0;
            bit_d  = 4'd0;
            sclk_d = 1'b0;
            mosi_d = 1'b1;
            if (load) begin
                // Fresh load: no DataClk, the first bit goes out immediately.
                tx_d   = bus.OutputData;
                fast_d = bus.SPI_FastMode;
                mosi_d = bus.OutputData[7];
            end
        end else if (half_done) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
                // Rising SPI_CLK: capture the bit and count it.
                rx_d  = {rx_q[6:0], rx_bit};
                bit_d = bit_q + 4'd1;
            end else if (bit_q == 4'd8) begin
                // Falling SPI_CLK after bit 8: publish the byte and reload so
                // the next byte follows with no clock gap.
                din_d  = rx_q;
                dclk_d = 1'b1;
                tx_d   = bus.OutputData;
                fast_d = bus.SPI_FastMode;
                mosi_d = bus.OutputData[7];
                bit_d  = 4'd0;
            end else begin
                // Falling SPI_CLK mid-byte: present the next TX bit.
                tx_d   = {tx_q[6:0], 1'b0};
                mosi_d = tx_q[6];
            end
        end else begin
            div_d = div_q + DivW'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= 4'd0;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            din_q   <= 8'h00;
            fast_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
            dclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            din_q   <= din_d;
            fast_q  <= fast_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            dclk_q  <= dclk_d;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        bus.InputData = din_q;
        bus.DataClk   = dclk_q;
        bus.SPI_MOSI  = mosi_q;
        bus.SPI_CLK   = sclk_q;
        bus.dbg_shift = (state_q == ST_SHIFT);
    end

endmodule

// File: tb/tb_full_spi.sv
// tb_full_spi: bench for the full_spi SPI master byte engine.
// A card model answers on MISO and records the MOSI bytes it sees. Expected
// timing comes from the byte-period arithmetic: the first rise comes H cycles
// after the load, and each boundary comes 16*H cycles after the previous one.
// Expected bytes follow the one-byte pipeline rule for OutputData.
module tb_full_spi;

    localparam int H_FAST = 2;   // 50 MHz / (2 * 12.5 MHz)
    localparam int H_SLOW = 71;  // floor(50 MHz / (2 * 350 kHz))
`ifdef FULL_SPI_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    full_spi_if bus ();

    full_spi dut (
        .MasterCLK (clk),
        .Reset     (rst_n),
        .bus       (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Monitor / card model state.
    logic       sclk_prev = 1'b0;
    int         rise_q[$];
    int         dclk_q[$];
    logic [7:0] din_q[$];
    logic [7:0] got_q[$];
    logic [7:0] card_q[$];
    logic [7:0] card_used[$];
    logic [7:0] out_list[$];
    logic [7:0] card_cur = 8'h00;
    logic [7:0] mosi_sr  = 8'h00;
    int         nbits    = 0;

    // The byte the engine should report: the card's byte, or what it sent
    // itself when looped back.
    function automatic logic [7:0] exp_rx(input logic [7:0] sent, input logic [7:0] card);
        return LOOPBACK ? sent : card;
    endfunction

    // Pick the card's next reply: a queued byte, or a random one if none.
    task automatic next_card_byte();
        if (card_q.size() > 0) card_cur = card_q.pop_front();
        else                   card_cur = 8'($urandom);
        card_used.push_back(card_cur);
    endtask

    // Clear the monitor queues and line up the card's first bit on MISO.
    task automatic clear_mon();
        rise_q.delete();
        dclk_q.delete();
        din_q.delete();
        got_q.delete();
        card_used.delete();
        nbits   = 0;
        mosi_sr = 8'h00;
        next_card_byte();
        bus.SPI_MISO = card_cur[7];
    endtask

    // Advance one cycle and sample on the falling MasterCLK edge.
    // The card model acts as an SPI mode-0 slave: it samples MOSI on the
    // rising SPI_CLK edge, then moves MISO to its next bit.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.SPI_CLK === 1'b1 && sclk_prev === 1'b0) begin
            rise_q.push_back(cyc);
            mosi_sr = {mosi_sr[6:0], bus.SPI_MOSI};
            nbits++;
            if (nbits == 8) begin
                got_q.push_back(mosi_sr);
                nbits = 0;
                next_card_byte();
            end
            bus.SPI_MISO = card_cur[3'(7 - nbits)];
        end
        if (bus.DataClk === 1'b1) begin
            dclk_q.push_back(cyc);
            din_q.push_back(bus.InputData);
            if (out_list.size() > 0) bus.OutputData = out_list.pop_front();
        end
        sclk_prev = bus.SPI_CLK;
    endtask

    // Step until n DataClk strobes have been seen, or the cycle budget runs out.
    task automatic wait_dclk(input int n, input int budget, output bit to);
        int k;
        k = 0;
        while (dclk_q.size() < n && k < budget) begin
            step();
            k++;
        end
        to = (dclk_q.size() < n);
    endtask

    // Step until n rising SPI_CLK edges have been seen, or the budget runs out.
    task automatic wait_rises(input int n, input int budget, output bit to);
        int k;
        k = 0;
        while (rise_q.size() < n && k < budget) begin
            step();
            k++;
        end
        to = (rise_q.size() < n);
    endtask

    // Hold Reset low with SPI_Enable high and check every output stays at its
    // reset value.
    task automatic test_reset();
        int bad;
        bus.SPI_Enable   = 1'b1;
        bus.SPI_FastMode = 1'b1;
        bus.OutputData   = 8'($urandom);
        bus.SPI_MISO     = 1'b1;
        rst_n            = 1'b0;
        bad              = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (bus.SPI_CLK !== 1'b0 || bus.DataClk !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_sclk_low: got %0d cycles with activity expected 0", bad);
        end
        n_checks++;
        if (bus.InputData !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_indata: got %h expected 00", bus.InputData);
        end
        n_checks++;
        if (bus.SPI_MOSI !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mosi: got %b expected 1", bus.SPI_MOSI);
        end
        n_checks++;
        if (bus.dbg_shift !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 0", bus.dbg_shift);
        end
        bus.SPI_Enable = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
    endtask

    // One fast byte: send 8'h40 while the card replies 8'h01.
    task automatic test_fast_byte();
        int e;
        bit to;
        bus.SPI_FastMode = 1'b1;
        bus.OutputData   = 8'h40;
        out_list.delete();
        card_q.delete();
        card_q.push_back(8'h01);
        clear_mon();
        e              = cyc;
        bus.SPI_Enable = 1'b1;
        wait_dclk(1, 200, to);
        bus.SPI_Enable = 1'b0;
        step();
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL fast_timeout: got no DataClk expected one within 200 cycles");
        end
        n_checks++;
        if (rise_q[0] != e + 1 + H_FAST) begin
            n_fail++;
            $display("FAIL fast_first_rise: got %0d expected %0d", rise_q[0], e + 1 + H_FAST);
        end
        n_checks++;
        if (dclk_q[0] != e + 1 + 16 * H_FAST) begin
            n_fail++;
            $display("FAIL fast_dclk_time: got %0d expected %0d", dclk_q[0], e + 1 + 16 * H_FAST);
        end
        n_checks++;
        if (got_q[0] !== 8'h40) begin
            n_fail++;
            $display("FAIL fast_mosi_byte: got %h expected 40", got_q[0]);
        end
        n_checks++;
        if (din_q[0] !== exp_rx(8'h40, 8'h01)) begin
            n_fail++;
            $display("FAIL fast_indata: got %h expected %h", din_q[0], exp_rx(8'h40, 8'h01));
        end
        n_checks++;
        if (bus.SPI_CLK !== 1'b0 || bus.SPI_MOSI !== 1'b1) begin
            n_fail++;
            $display("FAIL fast_park: got clk=%b mosi=%b expected clk=0 mosi=1", bus.SPI_CLK, bus.SPI_MOSI);
        end
    endtask

    // Three bytes back to back. OutputData changes 40 -> 95 at the first strobe,
    // so the bytes sent are 40, 40, 95.
    task automatic test_back_to_back();
        int  e;
        int  bad;
        bit  to;
        logic [7:0] exp_tx[3];
        exp_tx[0]        = 8'h40;
        exp_tx[1]        = 8'h40;
        exp_tx[2]        = 8'h95;
        bus.SPI_FastMode = 1'b1;
        bus.OutputData   = 8'h40;
        out_list.delete();
        out_list.push_back(8'h95);
        card_q.delete();
        clear_mon();
        e              = cyc;
        bus.SPI_Enable = 1'b1;
        wait_dclk(3, 300, to);
        bus.SPI_Enable = 1'b0;
        step();
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d strobes expected 3", dclk_q.size());
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dclk_q[k] != e + 1 + 16 * H_FAST * (k + 1)) begin
                n_fail++;
                $display("FAIL b2b_dclk_time[%0d]: got %0d expected %0d", k, dclk_q[k], e + 1 + 16 * H_FAST * (k + 1));
            end
            n_checks++;
            if (got_q[k] !== exp_tx[k]) begin
                n_fail++;
                $display("FAIL b2b_mosi[%0d]: got %h expected %h", k, got_q[k], exp_tx[k]);
            end
            n_checks++;
            if (din_q[k] !== exp_rx(exp_tx[k], card_used[k])) begin
                n_fail++;
                $display("FAIL b2b_indata[%0d]: got %h expected %h", k, din_q[k], exp_rx(exp_tx[k], card_used[k]));
            end
        end
        bad = 0;
        for (int i = 1; i < rise_q.size(); i++)
            if (rise_q[i] - rise_q[i-1] != 2 * H_FAST) bad++;
        n_checks++;
        if (bad != 0 || rise_q.size() != 24) begin
            n_fail++;
            $display("FAIL b2b_clock_gap: got %0d bad spacings over %0d rises expected 0 over 24", bad, rise_q.size());
        end
    endtask

    // Random byte streams at a random rate, checked against the pipeline rule:
    // the bytes sent are lst[0], lst[0], lst[1], ..., lst[n-2].
    task automatic test_random_stream();
        logic [7:0] lst[$];
        logic [7:0] exp_tx[$];
        int  n;
        int  h;
        int  e;
        bit  fast;
        bit  to;
        for (int r = 0; r < 5; r++) begin
            fast = ($urandom_range(0, 3) != 0);
            n    = fast ? $urandom_range(2, 6) : 2;
            h    = fast ? H_FAST : H_SLOW;
            lst.delete();
            exp_tx.delete();
            for (int i = 0; i < n; i++) lst.push_back(8'($urandom));
            exp_tx.push_back(lst[0]);
            for (int i = 0; i < n - 1; i++) exp_tx.push_back(lst[i]);
            bus.SPI_FastMode = fast;
            bus.OutputData   = lst[0];
            card_q.delete();
            clear_mon();
            out_list.delete();
            for (int i = 1; i < n; i++) out_list.push_back(lst[i]);
            e              = cyc;
            bus.SPI_Enable = 1'b1;
            wait_dclk(n, n * 16 * h + 20, to);
            bus.SPI_Enable = 1'b0;
            step();
            step();
            n_checks++;
            if (to) begin
                n_fail++;
                $display("FAIL rnd_timeout[%0d]: got %0d strobes expected %0d", r, dclk_q.size(), n);
            end
            for (int k = 0; k < n; k++) begin
                n_checks++;
                if (got_q[k] !== exp_tx[k]) begin
                    n_fail++;
                    $display("FAIL rnd_mosi[%0d][%0d]: got %h expected %h", r, k, got_q[k], exp_tx[k]);
                end
                n_checks++;
                if (din_q[k] !== exp_rx(exp_tx[k], card_used[k])) begin
                    n_fail++;
                    $display("FAIL rnd_indata[%0d][%0d]: got %h expected %h", r, k, din_q[k], exp_rx(exp_tx[k], card_used[k]));
                end
                n_checks++;
                if (dclk_q[k] != e + 1 + 16 * h * (k + 1)) begin
                    n_fail++;
                    $display("FAIL rnd_dclk_time[%0d][%0d]: got %0d expected %0d", r, k, dclk_q[k], e + 1 + 16 * h * (k + 1));
                end
            end
        end
    endtask

    // Slow byte; switching to fast mid-byte only takes effect at the next load.
    task automatic test_slow_then_fast();
        logic [7:0] a;
        int  e;
        bit  to;
        bit  to2;
        a                = 8'($urandom);
        bus.SPI_FastMode = 1'b0;
        bus.OutputData   = a;
        out_list.delete();
        card_q.delete();
        clear_mon();
        e              = cyc;
        bus.SPI_Enable = 1'b1;
        wait_rises(3, 400, to);
        bus.SPI_FastMode = 1'b1;
        wait_dclk(2, 16 * H_SLOW + 16 * H_FAST + 50, to2);
        bus.SPI_Enable = 1'b0;
        step();
        n_checks++;
        if (to || to2) begin
            n_fail++;
            $display("FAIL slow_timeout: got rises=%0d strobes=%0d expected 3 and 2", rise_q.size(), dclk_q.size());
        end
        n_checks++;
        if (rise_q[0] != e + 1 + H_SLOW) begin
            n_fail++;
            $display("FAIL slow_first_rise: got %0d expected %0d", rise_q[0], e + 1 + H_SLOW);
        end
        n_checks++;
        if (rise_q[1] - rise_q[0] != 2 * H_SLOW) begin
            n_fail++;
            $display("FAIL slow_period: got %0d expected %0d", rise_q[1] - rise_q[0], 2 * H_SLOW);
        end
        n_checks++;
        if (dclk_q[0] != e + 1 + 16 * H_SLOW) begin
            n_fail++;
            $display("FAIL slow_dclk_time: got %0d expected %0d", dclk_q[0], e + 1 + 16 * H_SLOW);
        end
        n_checks++;
        if (dclk_q[1] - dclk_q[0] != 16 * H_FAST) begin
            n_fail++;
            $display("FAIL slow_to_fast_spacing: got %0d expected %0d", dclk_q[1] - dclk_q[0], 16 * H_FAST);
        end
        n_checks++;
        if (got_q[0] !== a || got_q[1] !== a) begin
            n_fail++;
            $display("FAIL slow_mosi: got %h %h expected %h %h", got_q[0], got_q[1], a, a);
        end
        n_checks++;
        if (din_q[0] !== exp_rx(a, card_used[0])) begin
            n_fail++;
            $display("FAIL slow_indata: got %h expected %h", din_q[0], exp_rx(a, card_used[0]));
        end
    endtask

    // Abort after 3 bits, then re-enable for a fresh, complete byte.
    task automatic test_abort();
        logic [7:0] prev;
        logic [7:0] b;
        logic [7:0] c;
        int  e;
        bit  to;
        prev             = bus.InputData;
        b                = 8'($urandom);
        bus.SPI_FastMode = 1'b1;
        bus.OutputData   = b;
        out_list.delete();
        card_q.delete();
        clear_mon();
        bus.SPI_Enable = 1'b1;
        wait_rises(3, 40, to);
        bus.SPI_Enable = 1'b0;
        step();
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL abort_timeout: got %0d rises expected 3", rise_q.size());
        end
        n_checks++;
        if (bus.SPI_CLK !== 1'b0 || bus.SPI_MOSI !== 1'b1 || bus.dbg_shift !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_park: got clk=%b mosi=%b st=%b expected 0 1 0", bus.SPI_CLK, bus.SPI_MOSI, bus.dbg_shift);
        end
        for (int i = 0; i < 60; i++) step();
        n_checks++;
        if (dclk_q.size() != 0 || rise_q.size() != 3) begin
            n_fail++;
            $display("FAIL abort_quiet: got strobes=%0d rises=%0d expected 0 and 3", dclk_q.size(), rise_q.size());
        end
        n_checks++;
        if (bus.InputData !== prev) begin
            n_fail++;
            $display("FAIL abort_indata: got %h expected %h", bus.InputData, prev);
        end
        c              = 8'($urandom);
        bus.OutputData = c;
        clear_mon();
        e              = cyc;
        bus.SPI_Enable = 1'b1;
        wait_dclk(1, 60, to);
        bus.SPI_Enable = 1'b0;
        step();
        n_checks++;
        if (to || dclk_q[0] != e + 1 + 16 * H_FAST) begin
            n_fail++;
            $display("FAIL reenable_dclk_time: got %0d expected %0d", dclk_q[0], e + 1 + 16 * H_FAST);
        end
        n_checks++;
        if (rise_q[0] != e + 1 + H_FAST) begin
            n_fail++;
            $display("FAIL reenable_first_rise: got %0d expected %0d", rise_q[0], e + 1 + H_FAST);
        end
        n_checks++;
        if (got_q[0] !== c) begin
            n_fail++;
            $display("FAIL reenable_mosi: got %h expected %h", got_q[0], c);
        end
        n_checks++;
        if (din_q[0] !== exp_rx(c, card_used[0])) begin
            n_fail++;
            $display("FAIL reenable_indata: got %h expected %h", din_q[0], exp_rx(c, card_used[0]));
        end
    endtask

    // Reset asserted between clock edges in the middle of the second byte.
    task automatic test_reset_mid();
        logic [7:0] a;
        bit to;
        bit to2;
        a                = 8'($urandom);
        bus.SPI_FastMode = 1'b1;
        bus.OutputData   = a;
        out_list.delete();
        card_q.delete();
        card_q.push_back(8'h5A);
        clear_mon();
        bus.SPI_Enable = 1'b1;
        wait_dclk(1, 60, to);
        wait_rises(11, 40, to2);
        n_checks++;
        if (to || to2 || din_q[0] !== exp_rx(a, 8'h5A)) begin
            n_fail++;
            $display("FAIL rstmid_pre: got %h expected %h", din_q[0], exp_rx(a, 8'h5A));
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.SPI_CLK !== 1'b0 || bus.SPI_MOSI !== 1'b1 || bus.DataClk !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_lines: got clk=%b mosi=%b dclk=%b expected 0 1 0", bus.SPI_CLK, bus.SPI_MOSI, bus.DataClk);
        end
        n_checks++;
        if (bus.InputData !== 8'h00 || bus.dbg_shift !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_regs: got indata=%h st=%b expected 00 0", bus.InputData, bus.dbg_shift);
        end
        step();
        bus.SPI_Enable = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

`ifdef FULL_SPI_LOOPBACK_EN
    // Loopback: 8'hA5 sent twice must come back as 8'hA5 whatever MISO does.
    task automatic test_loopback();
        bit to;
        bus.SPI_FastMode = 1'b1;
        bus.OutputData   = 8'hA5;
        out_list.delete();
        card_q.delete();
        clear_mon();
        bus.SPI_Enable = 1'b1;
        wait_dclk(2, 120, to);
        bus.SPI_Enable = 1'b0;
        step();
        n_checks++;
        if (to || din_q[1] !== 8'hA5) begin
            n_fail++;
            $display("FAIL loopback_indata: got %h expected a5", din_q[1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fast_byte();
        test_back_to_back();
        test_random_stream();
        test_slow_then_fast();
        test_abort();
        test_reset_mid();
`ifdef FULL_SPI_LOOPBACK_EN
        test_loopback();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of test expected finish before 3000000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
